pixel_array_responder: RTL and testbench

- Synthesizable digital model of the 2x2 pixel array: the responder end of the pixel control and data-bus protocol.
- The array controller drives erase/expose/convert/read1/read2 and a shared ramp code. This block integrates light, latches the ramp code when each pixel's comparator trips, and returns pixel codes row by row.
- Replaces the tristate bus with split ramp-in and data-out ports so it can be synthesized; it sits between the sequencer and the readout capture.

---
 rtl/pixel_array_responder.sv | 138 +++++++++++++
 tb/tb_pixel_array_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pixel_array_responder.sv
// Responder side of the 2x2 pixel array: integrates light, latches the shared ramp on comparator trip, reads rows out.
// Optional build macro PIX_GRAY_RAMP_EN: ramp_in is Gray-coded, compare and readout use the binary value.
module pixel_array_responder #(
  parameter int DATA_W  = 8,
  parameter int LIGHT_W = 8,
  parameter int ACC_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               erase,
  input  logic               expose,
  input  logic               convert,
  input  logic               read1,
  input  logic               read2,
  input  logic [LIGHT_W-1:0] light1,
  input  logic [LIGHT_W-1:0] light2,
  input  logic [LIGHT_W-1:0] light3,
  input  logic [LIGHT_W-1:0] light4,
  input  logic [DATA_W-1:0]  ramp_in,
  output logic [DATA_W-1:0]  pix_data1,
  output logic [DATA_W-1:0]  pix_data2,
  output logic               pix_valid,
  output logic [3:0]         tripped,
  output logic               seq_error
);

  typedef enum logic [2:0] {
    PH_IDLE, PH_ERASE, PH_EXPOSE, PH_CONVERT, PH_READ1, PH_READ2
  } phase_t;

  phase_t              phase_p0;
  logic                multi_p0;
  logic [4:0]          ctrl_p0;
  logic [LIGHT_W-1:0]  light [4];
  logic [ACC_W-1:0]    acc   [4];
  logic [DATA_W-1:0]   mem   [4];
  logic [DATA_W-1:0]   ramp_cmp_p0;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [LIGHT_W-1:0] inc);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W+1-LIGHT_W){1'b0}}, inc};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

`ifdef PIX_GRAY_RAMP_EN
  function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b[DATA_W-1] = g[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] rd_code(input logic [DATA_W-1:0] m);
    return gray2bin(m);
  endfunction

  assign ramp_cmp_p0 = gray2bin(ramp_in);
`else
  function automatic logic [DATA_W-1:0] rd_code(input logic [DATA_W-1:0] m);
    return m;
  endfunction

  assign ramp_cmp_p0 = ramp_in;
`endif

  assign light[0] = light1;
  assign light[1] = light2;
  assign light[2] = light3;
  assign light[3] = light4;

  // Stage p0: phase decode; any overlap of controls freezes all state for the cycle
  assign ctrl_p0  = {read2, read1, convert, expose, erase};
  assign multi_p0 = (ctrl_p0 & (ctrl_p0 - 5'd1)) != 5'd0;

  always_comb begin
    phase_p0 = PH_IDLE;
    case (ctrl_p0)
      5'b00001: phase_p0 = PH_ERASE;
      5'b00010: phase_p0 = PH_EXPOSE;
      5'b00100: phase_p0 = PH_CONVERT;
      5'b01000: phase_p0 = PH_READ1;
      5'b10000: phase_p0 = PH_READ2;
      default:  phase_p0 = PH_IDLE;
    endcase
  end

  // Stage p1: pixel state and readout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
        mem[i] <= '0;
      end
      tripped   <= '0;
      pix_data1 <= '0;
      pix_data2 <= '0;
      pix_valid <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (multi_p0) seq_error <= 1'b1;
      case (phase_p0)
        PH_ERASE: begin
          for (int i = 0; i < 4; i++) begin
            acc[i] <= '0;
            mem[i] <= '0;
          end
          tripped <= '0;
        end
        PH_EXPOSE: begin
          for (int i = 0; i < 4; i++) acc[i] <= sat_add(acc[i], light[i]);
        end
        PH_CONVERT: begin
          // Memory follows the ramp until the comparator fires, then freezes
          for (int i = 0; i < 4; i++) begin
            if (!tripped[i]) begin
              mem[i]     <= ramp_in;
              tripped[i] <= ramp_cmp_p0 >= acc[i][ACC_W-1 -: DATA_W];
            end
          end
        end
        PH_READ1: begin
          pix_data1 <= rd_code(mem[0]);
          pix_data2 <= rd_code(mem[1]);
          pix_valid <= 1'b1;
        end
        PH_READ2: begin
          pix_data1 <= rd_code(mem[2]);
          pix_data2 <= rd_code(mem[3]);
          pix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_array_responder.sv
// Directed bench for pixel_array_responder; ramp is Gray-encoded when PIX_GRAY_RAMP_EN is defined.
module tb_pixel_array_responder;
  localparam int DATA_W  = 8;
  localparam int LIGHT_W = 8;
  localparam int ACC_W   = 16;

  logic               clk = 1'b0;
  logic               reset, erase, expose, convert, read1, read2;
  logic [LIGHT_W-1:0] light1, light2, light3, light4;
  logic [DATA_W-1:0]  ramp_in;
  logic [DATA_W-1:0]  pix_data1, pix_data2;
  logic               pix_valid, seq_error;
  logic [3:0]         tripped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_array_responder #(.DATA_W(DATA_W), .LIGHT_W(LIGHT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .erase(erase), .expose(expose), .convert(convert),
    .read1(read1), .read2(read2), .light1(light1), .light2(light2),
    .light3(light3), .light4(light4), .ramp_in(ramp_in),
    .pix_data1(pix_data1), .pix_data2(pix_data2), .pix_valid(pix_valid),
    .tripped(tripped), .seq_error(seq_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] enc(input int v);
    logic [DATA_W-1:0] b;
    b = DATA_W'(v);
`ifdef PIX_GRAY_RAMP_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_lights(input int a, input int b, input int c, input int d);
    light1 = LIGHT_W'(a); light2 = LIGHT_W'(b); light3 = LIGHT_W'(c); light4 = LIGHT_W'(d);
  endtask

  task automatic erase_n(input int n);
    erase = 1'b1; repeat (n) cyc(); erase = 1'b0;
  endtask

  task automatic expose_n(input int n);
    expose = 1'b1; repeat (n) cyc(); expose = 1'b0;
  endtask

  task automatic convert_ramp(input int last);
    for (int v = 0; v <= last; v++) begin
      convert = 1'b1; ramp_in = enc(v); cyc();
    end
    convert = 1'b0;
  endtask

  task automatic read_row(input bit row2, input int e1, input int e2, input string tag);
    if (row2) read2 = 1'b1; else read1 = 1'b1;
    cyc();
    check({tag, "_valid"}, 32'(pix_valid), 32'd1);
    check({tag, "_d1"}, 32'(pix_data1), 32'(e1));
    check({tag, "_d2"}, 32'(pix_data2), 32'(e2));
    read1 = 1'b0; read2 = 1'b0;
    cyc();
    check({tag, "_valid_after"}, 32'(pix_valid), 32'd0);
    check({tag, "_d1_hold"}, 32'(pix_data1), 32'(e1));
  endtask

  initial begin
    reset = 1'b1; erase = 1'b0; expose = 1'b0; convert = 1'b0; read1 = 1'b0; read2 = 1'b0;
    ramp_in = '0;
    set_lights(0, 0, 0, 0);
    cyc(); cyc();
    reset = 1'b0;
    check("rst_d1", 32'(pix_data1), 0);
    check("rst_d2", 32'(pix_data2), 0);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_tripped", 32'(tripped), 0);
    check("rst_seq_error", 32'(seq_error), 0);

    // Nominal: light1=128 for 255 cycles -> acc 32640, level 127; dark pixels trip at 0
    set_lights(128, 0, 0, 0);
    erase_n(5);
    check("nom_erase_tripped", 32'(tripped), 0);
    expose_n(255);
    for (int v = 0; v <= 254; v++) begin
      convert = 1'b1; ramp_in = enc(v); cyc();
      if (v == 0)   check("nom_trip_at0", 32'(tripped), 32'b1110);
      if (v == 126) check("nom_trip_at126", 32'(tripped), 32'b1110);
      if (v == 127) check("nom_trip_at127", 32'(tripped), 32'b1111);
    end
    convert = 1'b0;
    cyc();
    check("nom_idle_valid", 32'(pix_valid), 0);
    read_row(1'b0, 127, 0, "nom_r1");
    read_row(1'b0, 127, 0, "nom_r1_again");
    read_row(1'b1, 0, 0, "nom_r2");

    // Saturation: 255 x 300 clamps at 65535 -> level 255, never trips on a ramp ending at 254
    set_lights(0, 0, 255, 255);
    erase_n(5);
    expose_n(300);
    convert_ramp(254);
    check("sat_tripped", 32'(tripped), 32'b0011);
    read_row(1'b1, 254, 254, "sat_r2");
    read_row(1'b0, 0, 0, "sat_r1");

    // Row select: levels 31/63/95/159
    set_lights(32, 64, 96, 160);
    erase_n(3);
    expose_n(255);
    convert_ramp(254);
    check("row_tripped", 32'(tripped), 32'b1111);
    read_row(1'b0, 31, 63, "row_r1");
    read_row(1'b1, 95, 159, "row_r2");

    // Illegal overlap mid-exposure must leave acc untouched (levels stay 31/63)
    erase_n(3);
    expose_n(100);
    erase = 1'b1; expose = 1'b1; cyc();
    erase = 1'b0; expose = 1'b0;
    check("ill_seq_error", 32'(seq_error), 1);
    expose_n(155);
    check("ill_seq_sticky", 32'(seq_error), 1);
    convert_ramp(254);
    read1 = 1'b1; read2 = 1'b1; cyc();
    check("ill_dual_read_valid", 32'(pix_valid), 0);
    check("ill_dual_read_hold", 32'(pix_data1), 95);
    read1 = 1'b0; read2 = 1'b0;
    read_row(1'b0, 31, 63, "ill_r1");
    check("ill_seq_still", 32'(seq_error), 1);

    // Reset mid-convert
    erase_n(3);
    expose_n(255);
    convert_ramp(59);
    check("mid_tripped_pre", 32'(tripped), 32'b0001);
    reset = 1'b1; convert = 1'b1; ramp_in = enc(60); cyc();
    reset = 1'b0; convert = 1'b0;
    check("mid_rst_tripped", 32'(tripped), 0);
    check("mid_rst_d1", 32'(pix_data1), 0);
    check("mid_rst_d2", 32'(pix_data2), 0);
    check("mid_rst_valid", 32'(pix_valid), 0);
    check("mid_rst_seq_error", 32'(seq_error), 0);
    read_row(1'b0, 0, 0, "mid_mem_r1");
    read_row(1'b1, 0, 0, "mid_mem_r2");
    erase_n(2);
    expose_n(255);
    convert_ramp(254);
    read_row(1'b0, 31, 63, "fresh_r1");
    read_row(1'b1, 95, 159, "fresh_r2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
